ball_launch_fsm: RTL and testbench
==================================

Name: ball_launch_fsm

Overview:
- Frame-synchronous launch sequencer directly downstream of the spring block.
- Watches key5 plus the spring's reported speedY and decides when, and how fast, the ball leaves the plunger lane.
- Emits a one-clock launch pulse and a latched launch velocity to the ball controller.
- Tracks in-play vs. on-spring so the spring is ignored while the ball is live.

Parameters:
- MIN_CHARGE_FRAMES, 4: frames key5 must be held before a release counts as a launch.
- MIN_LAUNCH_SPEED, 2: minimum |speedY| at release for a valid launch; below this is a weak pull and no launch occurs.
- MAX_LAUNCH_SPEED, 400: clamp on launch speed magnitude.
- COOLDOWN_FRAMES, 30: frames to wait after ballLost (optional feature only).

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous active-low reset
- startOfFrame  in  1  one-clock pulse per video frame
- key5IsPressed  in  1  plunger key level
- reset_level  in  1  synchronous level restart
- springSpeedY  in  32 (int, signed)  speedY from the spring block
- ballLost  in  1  ball drained; pulse or level
- launchPulse  out  1  high exactly one clock per launch
- launchSpeedY  out  32 (int, signed)  latched launch velocity; negative means upward
- ballOnSpring  out  1  ball resting in plunger lane
- launchCount  out  8  launches since reset, saturating at 255

Behaviour:
- Interface: one clock (clk). Reset (resetN) is synchronous and active-low. All registers update on the clk rising edge only.
- Reset values: state READY, launchPulse 0, launchSpeedY 0, ballOnSpring 1, launchCount 0, chargeFrames 0.
- Priority: resetN low > reset_level high > normal operation.
- reset_level forces READY and clears chargeFrames, launchPulse and launchSpeedY. It does not clear launchCount.
- Frame sampling: key5IsPressed is evaluated only in cycles where startOfFrame=1. ballLost is evaluated every cycle.
- State READY:
  - ballOnSpring=1.
  - On startOfFrame with key pressed: go to CHARGING, set chargeFrames=0.
- State CHARGING:
  - On each startOfFrame with key still pressed: chargeFrames increments, saturating at 255.
  - On startOfFrame with key released: compute mag = |springSpeedY|. Treat the most negative int as MAX_LAUNCH_SPEED.
  - If chargeFrames >= MIN_CHARGE_FRAMES and mag >= MIN_LAUNCH_SPEED: go to LAUNCH and latch launchSpeedY = -min(mag, MAX_LAUNCH_SPEED).
  - Otherwise go to READY; launchSpeedY is unchanged.
- State LAUNCH:
  - Lasts exactly one clock. launchPulse=1 in this clock and launchCount increments, saturating.
  - Next state is IN_PLAY.
- Latency: release sampled in cycle N; launchPulse and the new launchSpeedY are visible in cycle N+1; ballOnSpring falls in cycle N+2.
- State IN_PLAY:
  - ballOnSpring=0. launchSpeedY holds. key5 and springSpeedY are ignored.
  - ballLost=1 goes to READY, or to COOLDOWN when the optional feature is built.
- ballLost in READY, CHARGING or LAUNCH is ignored.
- ballLost and reset_level in the same cycle: reset_level wins; result is READY.
- Key held through a reset_level: the FSM re-enters CHARGING at the next startOfFrame with chargeFrames=0.

Optional Feature:
- Macro: BALL_LAUNCH_COOLDOWN_EN.
- With the macro defined:
  - Adds state COOLDOWN. ballLost in IN_PLAY goes to COOLDOWN with ballOnSpring=1.
  - A frame counter counts startOfFrame pulses and returns to READY after COOLDOWN_FRAMES frames.
  - A key press during COOLDOWN is ignored, even if still held at exit. CHARGING requires the key to be pressed on a startOfFrame after READY is entered.
  - reset_level in COOLDOWN goes to READY immediately.
- Without the macro: no COOLDOWN state and no counter; ballLost goes straight to READY.

Decomposition:
- Shared package defines gets:
  - enum launch_state_t {READY, CHARGING, LAUNCH, IN_PLAY, COOLDOWN}
  - constants LAUNCH_MIN_CHARGE_FRAMES, LAUNCH_MIN_SPEED, LAUNCH_MAX_SPEED, LAUNCH_COOLDOWN_FRAMES, used as parameter defaults.
- One sub-module: frame_counter (clk, resetN, clear, startOfFrame, count[7:0], saturating). It is used for chargeFrames and for cooldown.

Test Plan:
- Hold key5 6 frames, release with springSpeedY=-120 → launchPulse high 1 clock at N+1, launchSpeedY=-120, launchCount=1, ballOnSpring=0 at N+2.
- Hold key5 2 frames (MIN_CHARGE_FRAMES=4), release with speedY=-120 → no launchPulse, state READY, launchSpeedY stays 0.
- Hold 10 frames, release with springSpeedY=-900 → launchSpeedY=-400 (clamp); separately, release with speedY=1 → no launch.
- In IN_PLAY, toggle key5 for 10 frames → no state change. Then ballLost pulse → READY next clock (macro off), or READY after 30 startOfFrame pulses (macro on), with a held key not launching.
- Assert reset_level in the same cycle as ballLost, and separately during CHARGING → READY, chargeFrames=0, launchCount preserved. resetN low → all outputs at reset values next clock.
- Perform 260 valid launches → launchCount saturates at 255.

Source files
------------

// File: rtl/ball_launch_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ball_launch_fsm_pkg
// Description : Shared types and default constants for the ball launch
//               sequencer. This file has no ports. It defines:
//                 - launch_state_t : sequencer state encoding
//                 - LAUNCH_*       : default parameter values
//                 - speed_magnitude: |speedY|, safe for the most negative int
//               Optional feature macro used by the consumers of this
//               package: BALL_LAUNCH_COOLDOWN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package ball_launch_fsm_pkg;

  localparam int LAUNCH_MIN_CHARGE_FRAMES = 4;
  localparam int LAUNCH_MIN_SPEED         = 2;
  localparam int LAUNCH_MAX_SPEED         = 400;
  localparam int LAUNCH_COOLDOWN_FRAMES   = 30;

  typedef enum logic [2:0] {
    READY    = 3'd0,
    CHARGING = 3'd1,
    LAUNCH   = 3'd2,
    IN_PLAY  = 3'd3,
    COOLDOWN = 3'd4
  } launch_state_t;

  // The most negative int has no positive two's-complement counterpart, so it
  // maps straight to the clamp value instead of wrapping back to itself.
  function automatic logic [31:0] speed_magnitude(input logic signed [31:0] speed,
                                                  input logic [31:0]        max_speed);
    if (speed == 32'sh8000_0000) begin
      return max_speed;
    end else if (speed < 0) begin
      return $unsigned(-speed);
    end else begin
      return $unsigned(speed);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/ball_launch_fsm_frame_counter.sv
`default_nettype none
// ============================================================================
// Module      : ball_launch_fsm_frame_counter
// Description : Saturating 8-bit count of startOfFrame pulses. It is held at
//               zero while clear is high. It is used for the charge time and
//               for the post-drain cooldown of ball_launch_fsm.
// Ports       : clk          in   system clock
//               resetN       in   synchronous active-low reset
//               clear        in   synchronous clear (wins over counting)
//               startOfFrame in   one-clock pulse per video frame
//               count        out  frames counted, saturates at 255
// Revision    : 1.0 - initial release
// ============================================================================
module ball_launch_fsm_frame_counter (
  input  logic       clk,
  input  logic       resetN,
  input  logic       clear,
  input  logic       startOfFrame,
  output logic [7:0] count
);

  always_ff @(posedge clk) begin
    if (!resetN || clear) begin
      count <= 8'd0;
    end else if (startOfFrame && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ball_launch_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ball_launch_fsm
// Description : Frame-synchronous plunger launch sequencer. It sits after the
//               spring block. When key5 is released after a long enough
//               charge, it launches the ball with the spring's clamped speed.
//               It ignores the plunger while the ball is in play.
//               Optional feature: define BALL_LAUNCH_COOLDOWN_EN to add a
//               frame-counted cooldown after ballLost before READY.
// Ports       : clk           in   system clock
//               resetN        in   synchronous active-low reset
//               startOfFrame  in   one-clock pulse per video frame
//               key5IsPressed in   plunger key level
//               reset_level   in   synchronous level restart
//               springSpeedY  in   signed speedY from the spring block
//               ballLost      in   ball drained (pulse or level)
//               launchPulse   out  high for one clock per launch
//               launchSpeedY  out  latched launch velocity (negative = up)
//               ballOnSpring  out  ball resting in the plunger lane
//               launchCount   out  launches since reset, saturating at 255
// Revision    : 1.0 - initial release
// ============================================================================
module ball_launch_fsm
  import ball_launch_fsm_pkg::*;
#(
  parameter int MIN_CHARGE_FRAMES = LAUNCH_MIN_CHARGE_FRAMES,
  parameter int MIN_LAUNCH_SPEED  = LAUNCH_MIN_SPEED,
  parameter int MAX_LAUNCH_SPEED  = LAUNCH_MAX_SPEED,
  parameter int COOLDOWN_FRAMES   = LAUNCH_COOLDOWN_FRAMES
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               key5IsPressed,
  input  logic               reset_level,
  input  logic signed [31:0] springSpeedY,
  input  logic               ballLost,
  output logic               launchPulse,
  output logic signed [31:0] launchSpeedY,
  output logic               ballOnSpring,
  output logic [7:0]         launchCount
);

  launch_state_t state;

  // Charge timer: the counter holds at zero outside CHARGING. So entering
  // CHARGING always starts from zero, including after a reset_level.
  logic       charge_clear;
  logic [7:0] charge_frames;

  assign charge_clear = reset_level || (state != CHARGING);

  ball_launch_fsm_frame_counter u_charge_counter (
    .clk          (clk),
    .resetN       (resetN),
    .clear        (charge_clear),
    .startOfFrame (startOfFrame),
    .count        (charge_frames)
  );

  // Release evaluation, used only on the frame where the key is released.
  logic [31:0]        release_mag;
  logic [31:0]        launch_mag;
  logic               release_valid;
  logic signed [31:0] release_speed;

  always_comb begin
    release_mag   = speed_magnitude(springSpeedY, 32'(MAX_LAUNCH_SPEED));
    launch_mag    = (release_mag > 32'(MAX_LAUNCH_SPEED)) ? 32'(MAX_LAUNCH_SPEED) : release_mag;
    release_valid = ({24'd0, charge_frames} >= 32'(MIN_CHARGE_FRAMES)) &&
                    (release_mag >= 32'(MIN_LAUNCH_SPEED));
    release_speed = -$signed(launch_mag);
  end

`ifdef BALL_LAUNCH_COOLDOWN_EN
  logic       cool_clear;
  logic [7:0] cool_frames;
  logic       cool_done;

  assign cool_clear = reset_level || (state != COOLDOWN);

  ball_launch_fsm_frame_counter u_cool_counter (
    .clk          (clk),
    .resetN       (resetN),
    .clear        (cool_clear),
    .startOfFrame (startOfFrame),
    .count        (cool_frames)
  );

  // This frame is the COOLDOWN_FRAMES-th one counted in COOLDOWN.
  assign cool_done = startOfFrame && (({24'd0, cool_frames} + 32'd1) >= 32'(COOLDOWN_FRAMES));
`else
  logic [7:0] unused_cooldown_frames;
  assign unused_cooldown_frames = 8'(COOLDOWN_FRAMES);
`endif

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state        <= READY;
      launchPulse  <= 1'b0;
      launchSpeedY <= 32'sd0;
      ballOnSpring <= 1'b1;
      launchCount  <= 8'd0;
    end else if (reset_level) begin
      // launchCount deliberately survives a level restart.
      state        <= READY;
      launchPulse  <= 1'b0;
      launchSpeedY <= 32'sd0;
      ballOnSpring <= 1'b1;
    end else begin
      launchPulse <= 1'b0;
      case (state)
        READY: begin
          ballOnSpring <= 1'b1;
          if (startOfFrame && key5IsPressed) begin
            state <= CHARGING;
          end
        end

        CHARGING: begin
          if (startOfFrame && !key5IsPressed) begin
            if (release_valid) begin
              // Pulse, speed and count all become visible in the LAUNCH clock.
              state        <= LAUNCH;
              launchPulse  <= 1'b1;
              launchSpeedY <= release_speed;
              if (launchCount != 8'hFF) begin
                launchCount <= launchCount + 8'd1;
              end
            end else begin
              state <= READY;
            end
          end
        end

        LAUNCH: begin
          state        <= IN_PLAY;
          ballOnSpring <= 1'b0;
        end

        IN_PLAY: begin
          if (ballLost) begin
            ballOnSpring <= 1'b1;
`ifdef BALL_LAUNCH_COOLDOWN_EN
            state <= COOLDOWN;
`else
            state <= READY;
`endif
          end
        end

`ifdef BALL_LAUNCH_COOLDOWN_EN
        COOLDOWN: begin
          // The key is not looked at here. A held key must be seen again on
          // a frame in READY before charging starts.
          if (cool_done) begin
            state <= READY;
          end
        end
`endif

        default: begin
          state        <= READY;
          ballOnSpring <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ball_launch_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_ball_launch_fsm
// Description : Self-checking bench for ball_launch_fsm. A frame-level
//               behavioural model tracks what the outputs must be. A compare
//               process checks every cycle. Directed scenarios pin literal
//               values, and a randomized phase exercises mixed stimulus.
//               Honours BALL_LAUNCH_COOLDOWN_EN like the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_launch_fsm;

  localparam int COOL = 30;

  logic              clk = 1'b0;
  logic              resetN;
  logic              startOfFrame;
  logic              key5IsPressed;
  logic              reset_level;
  logic signed [31:0] springSpeedY;
  logic              ballLost;
  logic              launchPulse;
  logic signed [31:0] launchSpeedY;
  logic              ballOnSpring;
  logic [7:0]        launchCount;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  ball_launch_fsm dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .key5IsPressed (key5IsPressed),
    .reset_level   (reset_level),
    .springSpeedY  (springSpeedY),
    .ballLost      (ballLost),
    .launchPulse   (launchPulse),
    .launchSpeedY  (launchSpeedY),
    .ballOnSpring  (ballOnSpring),
    .launchCount   (launchCount)
  );

  // ---------------------------------------------------------------- model
  // The model works in frames: how many key-down frames were seen in the
  // current press, whether a ball is live, and how many cooldown frames are
  // left.
  bit m_charging, m_in_play, m_pulse, m_on;
  int m_held, m_cool, m_speed, m_count;

  function automatic longint magnitude(input int spd);
    longint v = longint'(spd);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit launch_ok(input int held, input int spd);
    int charge = (held - 1 > 255) ? 255 : held - 1;
    return (charge >= 4) && (magnitude(spd) >= 2);
  endfunction

  function automatic int launch_value(input int spd);
    longint m = magnitude(spd);
    return -int'((m > 400) ? 400 : m);
  endfunction

  always @(posedge clk) begin
    if (!resetN) begin
      m_charging = 0; m_in_play = 0; m_pulse = 0; m_on = 1;
      m_held = 0; m_cool = 0; m_speed = 0; m_count = 0;
    end else if (reset_level) begin
      m_charging = 0; m_in_play = 0; m_pulse = 0; m_on = 1;
      m_held = 0; m_cool = 0; m_speed = 0;
    end else if (m_pulse) begin
      m_pulse = 0; m_in_play = 1; m_on = 0;
    end else if (m_in_play) begin
      if (ballLost) begin
        m_in_play = 0; m_on = 1;
`ifdef BALL_LAUNCH_COOLDOWN_EN
        m_cool = COOL;
`endif
      end
    end else if (m_cool > 0) begin
      if (startOfFrame) m_cool--;
    end else if (m_charging) begin
      if (startOfFrame) begin
        if (key5IsPressed) begin
          m_held++;
        end else begin
          m_charging = 0;
          if (launch_ok(m_held, springSpeedY)) begin
            m_pulse = 1;
            m_speed = launch_value(springSpeedY);
            m_count = (m_count < 255) ? m_count + 1 : 255;
          end
        end
      end
    end else if (startOfFrame && key5IsPressed) begin
      m_charging = 1; m_held = 1;
    end
  end

  // -------------------------------------------------------------- checking
  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("launchPulse",  launchPulse,  m_pulse);
      chk("launchSpeedY", launchSpeedY, m_speed);
      chk("ballOnSpring", ballOnSpring, m_on);
      chk("launchCount",  launchCount,  m_count);
    end
  end

  // -------------------------------------------------------------- stimulus
  // Each step is entered at a negedge, drives inputs and waits one cycle.
  // After it returns, the outputs show the effect of that cycle's edge.
  task automatic step(input bit sof, input bit key, input int spd,
                      input bit lost, input bit rl);
    startOfFrame  = sof;
    key5IsPressed = key;
    springSpeedY  = spd;
    ballLost      = lost;
    reset_level   = rl;
    @(negedge clk);
  endtask

  task automatic frame(input bit key, input int spd);
    step(1, key, spd, 0, 0);
    step(0, key, spd, 0, 0);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) frame(1, -10);
  endtask

  // Drain the live ball and wait out any cooldown.
  task automatic drain();
    step(0, 0, 0, 1, 0);
`ifdef BALL_LAUNCH_COOLDOWN_EN
    for (int i = 0; i < COOL; i++) frame(0, 0);
`endif
  endtask

  initial begin
    int spd_pick;
    bit key_lvl;
    resetN = 0;
    step(0, 0, 0, 0, 0);
    check_en = 1;
    step(0, 1, -50, 1, 1);
    chk("rst_pulse", launchPulse, 0);
    chk("rst_speed", launchSpeedY, 0);
    chk("rst_onspring", ballOnSpring, 1);
    chk("rst_count", launchCount, 0);
    resetN = 1;
    step(0, 0, 0, 0, 0);

    // Short charge: 2 key frames gives chargeFrames 1, so no launch.
    hold(2);
    step(1, 0, -120, 0, 0);
    chk("short_pulse", launchPulse, 0);
    step(0, 0, 0, 0, 0);
    chk("short_speed", launchSpeedY, 0);
    chk("short_onspring", ballOnSpring, 1);

    // 6 frames, release at -120.
    hold(6);
    step(1, 0, -120, 0, 0);
    chk("l1_pulse", launchPulse, 1);
    chk("l1_speed", launchSpeedY, -120);
    chk("l1_count", launchCount, 1);
    chk("l1_onspring_n1", ballOnSpring, 1);
    chk("model_l1_speed", m_speed, -120);
    step(0, 0, 0, 0, 0);
    chk("l1_pulse_n2", launchPulse, 0);
    chk("l1_onspring_n2", ballOnSpring, 0);

    // Key toggling in play is ignored.
    for (int i = 0; i < 10; i++) frame(i[0], -300);
    chk("inplay_onspring", ballOnSpring, 0);
    chk("inplay_count", launchCount, 1);
    step(0, 0, 0, 1, 0);
`ifdef BALL_LAUNCH_COOLDOWN_EN
    for (int i = 0; i < COOL; i++) frame(1, -120);
    chk("cool_count", launchCount, 1);
    for (int i = 0; i < 2; i++) frame(0, 0);
`else
    chk("lost_onspring", ballOnSpring, 1);
`endif

    // Clamp at 400.
    hold(10);
    step(1, 0, -900, 0, 0);
    chk("clamp_speed", launchSpeedY, -400);
    chk("clamp_count", launchCount, 2);
    step(0, 0, 0, 0, 0);
    drain();

    // Weak pull (|speedY| = 1) does not launch.
    hold(6);
    step(1, 0, 1, 0, 0);
    chk("weak_pulse", launchPulse, 0);
    chk("weak_speed", launchSpeedY, -400);

    // reset_level mid-charge with the key still held restarts the charge.
    hold(3);
    step(0, 1, 0, 0, 1);
    chk("rl_count", launchCount, 2);
    chk("rl_speed", launchSpeedY, 0);
    hold(5);
    step(1, 0, -77, 0, 0);
    chk("rl_relaunch_pulse", launchPulse, 1);
    chk("rl_relaunch_speed", launchSpeedY, -77);
    chk("rl_relaunch_count", launchCount, 3);
    step(0, 0, 0, 0, 0);

    // reset_level and ballLost together in play.
    step(0, 0, 0, 1, 1);
    chk("rl_lost_onspring", ballOnSpring, 1);
    chk("rl_lost_speed", launchSpeedY, 0);
    chk("rl_lost_count", launchCount, 3);
    chk("model_rl_count", m_count, 3);

    // Randomized mixed stimulus.
    key_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) key_lvl = ~key_lvl;
      spd_pick = 0;
      case ($urandom_range(7))
        0: spd_pick = -int'($urandom_range(600));
        1: spd_pick = int'($urandom_range(600));
        2: spd_pick = 32'sh8000_0000;
        3: spd_pick = 0;
        4: spd_pick = 1;
        5: spd_pick = -2;
        6: spd_pick = -900;
        default: spd_pick = 2;
      endcase
      resetN = ($urandom_range(799) != 0);
      step($urandom_range(3) == 0, key_lvl, spd_pick,
           $urandom_range(39) == 0, $urandom_range(299) == 0);
    end
    resetN = 0;
    step(0, 0, 0, 0, 0);
    resetN = 1;

    // Saturation of launchCount.
    for (int n = 0; n < 260; n++) begin
      hold(5);
      step(1, 0, -50, 0, 0);
      step(0, 0, 0, 0, 0);
      drain();
    end
    chk("sat_count", launchCount, 255);
    chk("sat_speed", launchSpeedY, -50);

    resetN = 0;
    step(0, 1, -50, 0, 0);
    chk("final_rst_count", launchCount, 0);
    chk("final_rst_onspring", ballOnSpring, 1);
    chk("final_rst_speed", launchSpeedY, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
